// File: rtl/cpu_cycle_sched.sv
// 65816 CPU cycle scheduler: fast local-SRAM cycles or host-bus cycles aligned to host phi0.
// Define HOST_RDY_EN to let host RDY stretch host cycles (default build ignores host_rdy).
`timescale 1ns/1ps

module cpu_cycle_sched #(
  parameter int FAST_LO = 2,
  parameter int FAST_HI = 2
) (
  input  logic hsclk,
  input  logic rst,
  input  logic host_phi0,
  input  logic host_rdy,
  input  logic cpu_vda,
  input  logic cpu_vpa,
  input  logic cpu_rnw,
  input  logic req_host,
  input  logic fast_en,
  output logic cpu_phi2,
  output logic ram_ceb,
  output logic ram_oeb,
  output logic ram_web,
  output logic host_sel,
  output logic host_dlatch
);

  typedef enum logic [2:0] {
    IDLE, LO, HI, WAIT_P1, WAIT_P2, HOST_HI, HOST_END
  } state_t;

  localparam logic [2:0] LO_LOAD = 3'(FAST_LO - 1);
  localparam logic [2:0] HI_LOAD = 3'(FAST_HI - 1);

  state_t     state;
  logic [2:0] cnt;

  logic phi0_m, phi0_s, phi0_q;
  logic phi0_rise, phi0_fall;
  logic valid;

  assign phi0_rise = phi0_s & ~phi0_q;
  assign phi0_fall = ~phi0_s & phi0_q;
  assign valid     = cpu_vda | cpu_vpa;

  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge hsclk) begin
    if (rst) begin
      phi0_m <= 1'b0;
      phi0_s <= 1'b0;
      phi0_q <= 1'b0;
    end else begin
      phi0_m <= host_phi0;
      phi0_s <= phi0_m;
      phi0_q <= phi0_s;
    end
  end

`ifdef HOST_RDY_EN
  logic rdy_m, rdy_s;

  always_ff @(posedge hsclk) begin
    if (rst) begin
      rdy_m <= 1'b0;
      rdy_s <= 1'b0;
    end else begin
      rdy_m <= host_rdy;
      rdy_s <= rdy_m;
    end
  end
`else
  logic unused_rdy;
  assign unused_rdy = host_rdy;
`endif

  // Outputs are registered with the state: each transition sets what the next state drives.
  always_ff @(posedge hsclk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cpu_phi2    <= 1'b0;
      ram_ceb     <= 1'b1;
      ram_oeb     <= 1'b1;
      ram_web     <= 1'b1;
      host_sel    <= 1'b0;
      host_dlatch <= 1'b0;
    end else begin
      // NOTE: non-blocking default followed by a later override in the case gives a clean one-cycle pulse.
      host_dlatch <= 1'b0;
      unique case (state)
        IDLE: begin
          if (phi0_fall) begin
            state <= LO;
            cnt   <= LO_LOAD;
          end
        end
        LO: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else if (fast_en && !req_host) begin
            state    <= HI;
            cnt      <= HI_LOAD;
            cpu_phi2 <= 1'b1;
            ram_ceb  <= ~valid;
            ram_oeb  <= ~(valid & cpu_rnw);
            ram_web  <= ~(valid & ~cpu_rnw);
          end else begin
            state    <= WAIT_P1;
            cnt      <= '0;
            host_sel <= 1'b1;
          end
        end
        HI: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
            // Release the write strobe one cycle early so data is held past its rising edge.
            if (cnt == 3'd1) ram_web <= 1'b1;
          end else begin
            state    <= LO;
            cnt      <= LO_LOAD;
            cpu_phi2 <= 1'b0;
            ram_ceb  <= 1'b1;
            ram_oeb  <= 1'b1;
            ram_web  <= 1'b1;
          end
        end
        WAIT_P1: begin
          if (!phi0_s) begin
            state <= WAIT_P2;
            cnt   <= '0;
          end
        end
        WAIT_P2: begin
          // cpu_phi2 is left as-is: low on first entry, held high when RDY stretched the cycle.
          if (phi0_rise) begin
            state    <= HOST_HI;
            cnt      <= '0;
            cpu_phi2 <= 1'b1;
          end
        end
        HOST_HI: begin
          if (phi0_fall) begin
            cnt <= '0;
`ifdef HOST_RDY_EN
            if (!rdy_s) begin
              state <= WAIT_P2;
            end else begin
              state       <= HOST_END;
              host_dlatch <= 1'b1;
            end
`else
            state       <= HOST_END;
            host_dlatch <= 1'b1;
`endif
          end
        end
        HOST_END: begin
          state    <= LO;
          cnt      <= LO_LOAD;
          cpu_phi2 <= 1'b0;
          host_sel <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
